// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types, RAM mode encodings and the alignment check for
// the data-RAM arbiter.
// Ports: none (package).
// Optional feature macro used by the importing files: RAM_ARB_RR_EN.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  // Halfwords need an even address, words a 4-byte aligned one; bytes are always fine.
  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (mode[1:0])
      2'b01:        mis = addr_lo[0];
      2'b10, 2'b11: mis = (addr_lo != 2'b00);
      default:      mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational two-way request picker.
// Ports: req0/req1 - requests; last_gnt - port granted most recently
//        (1 = port 1); gnt - one-hot pick, bit i for port i, 0 when idle.
// Macro RAM_ARB_RR_EN: when defined, ties go to the port that did not win
// last time; otherwise port 0 always wins ties and last_gnt is ignored.
module ram_arb_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

`ifdef RAM_ARB_RR_EN
  // Round-robin on ties: port 0 wins only if port 1 won last.
  always_comb begin
    gnt = 2'b00;
    if (req0 && (!req1 || last_gnt)) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  // Fixed priority, port 0 first.
  always_comb begin
    gnt = 2'b00;
    if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer in front of the data RAM.
// Port 0 is the CPU load/store unit, port 1 the debug/program loader.
// One request is accepted at a time (IDLE or RESP), the RAM is driven for the
// single ACCESS cycle, and a registered response strobes in RESP.
// Ports: clk, rst (async, active-high);
//        mN_req/we/mode/addr/wdata in, mN_gnt (combinational) out,
//        mN_rvalid/rdata/rerr registered response out;
//        ram_we/mode/addr/din out, ram_dout in (combinational read).
// Macro RAM_ARB_RR_EN: round-robin tie-breaking via a last_gnt flop.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [2:0]        m0_mode,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rerr,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [2:0]        m1_mode,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rerr,
  output logic              ram_we,
  output logic [2:0]        ram_mode,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [2:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                rerr0_q, rerr0_d, rerr1_q, rerr1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                last_gnt_c;
  logic [1:0]          pick_c;
  logic                grant_ok_c;
  logic                mis_c;

  ram_arb_pick u_pick (
    .req0     (m0_req),
    .req1     (m1_req),
    .last_gnt (last_gnt_c),
    .gnt      (pick_c)
  );

`ifdef RAM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;

  // Remember which port won the most recent grant.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (m1_gnt) begin
      last_gnt_d = 1'b1;
    end else if (m0_gnt) begin
      last_gnt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign last_gnt_c = last_gnt_q;
`else
  assign last_gnt_c = 1'b1;
`endif

  // Grants are blocked in ACCESS and for as long as reset is held.
  assign grant_ok_c = !rst && (state_q != ACCESS);
  assign m0_gnt     = grant_ok_c && pick_c[0];
  assign m1_gnt     = grant_ok_c && pick_c[1];
  assign mis_c      = is_misaligned(mode_q, addr_q[1:0]);

  assign m0_rvalid = rvalid0_q;
  assign m0_rdata  = rdata0_q;
  assign m0_rerr   = rerr0_q;
  assign m1_rvalid = rvalid1_q;
  assign m1_rdata  = rdata1_q;
  assign m1_rerr   = rerr1_q;

  // Next-state, request latch, response capture and RAM drive.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rerr0_d   = rerr0_q;
    rerr1_d   = rerr1_q;
    ram_we    = 1'b0;
    ram_mode  = MODE_W;
    ram_addr  = '0;
    ram_din   = '0;

    case (state_q)
      IDLE, RESP: begin
        if (m0_gnt || m1_gnt) begin
          state_d = ACCESS;
          owner_d = m1_gnt;
          we_d    = m1_gnt ? m1_we    : m0_we;
          mode_d  = m1_gnt ? m1_mode  : m0_mode;
          addr_d  = m1_gnt ? m1_addr  : m0_addr;
          wdata_d = m1_gnt ? m1_wdata : m0_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        ram_we   = we_q && !mis_c;
        ram_mode = mode_q;
        ram_addr = addr_q;
        ram_din  = wdata_q;
        if (owner_q) begin
          rvalid1_d = 1'b1;
          rdata1_d  = mis_c ? '0 : ram_dout;
          rerr1_d   = mis_c;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = mis_c ? '0 : ram_dout;
          rerr0_d   = mis_c;
        end
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      mode_q    <= MODE_W;
      addr_q    <= '0;
      wdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rerr0_q   <= 1'b0;
      rerr1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rerr0_q   <= rerr0_d;
      rerr1_q   <= rerr1_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a byte-array RAM model
// (combinational read with sign/zero extension, write on the clock edge).
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              m0_req, m0_we, m0_gnt, m0_rvalid, m0_rerr;
  logic [2:0]        m0_mode;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_rerr;
  logic [2:0]        m1_mode;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              ram_we;
  logic [2:0]        ram_mode;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  logic [7:0]  mem [4096];
  logic [31:0] rd_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_mode(m0_mode), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_mode(m1_mode), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .ram_we(ram_we), .ram_mode(ram_mode), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model read path (little-endian).
  always_comb begin
    rd_word = {mem[{ram_addr[11:2], 2'd3}], mem[{ram_addr[11:2], 2'd2}],
               mem[{ram_addr[11:2], 2'd1}], mem[{ram_addr[11:2], 2'd0}]};
    rd_half = ram_addr[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte = rd_word[{ram_addr[1:0], 3'b000} +: 8];
    case (ram_mode)
      MODE_B:  ram_dout = {{24{rd_byte[7]}}, rd_byte};
      MODE_BU: ram_dout = {24'h0, rd_byte};
      MODE_H:  ram_dout = {{16{rd_half[15]}}, rd_half};
      MODE_HU: ram_dout = {16'h0, rd_half};
      default: ram_dout = rd_word;
    endcase
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] w);
    mem[{a[11:2], 2'd0}] = w[7:0];
    mem[{a[11:2], 2'd1}] = w[15:8];
    mem[{a[11:2], 2'd2}] = w[23:16];
    mem[{a[11:2], 2'd3}] = w[31:24];
  endtask

  // RAM model: preload, then commit writes on each rising edge.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    preload(12'h000, 32'h11223344);
    preload(12'h004, 32'h55667788);
    preload(12'h020, 32'h0BADC0DE);
    preload(12'h040, 32'h01020304);
    forever begin
      @(posedge clk);
      if (ram_we) begin
        case (ram_mode[1:0])
          2'b00: mem[ram_addr] = ram_din[7:0];
          2'b01: begin
            mem[{ram_addr[11:1], 1'b0}] = ram_din[7:0];
            mem[{ram_addr[11:1], 1'b1}] = ram_din[15:8];
          end
          default: begin
            mem[{ram_addr[11:2], 2'd0}] = ram_din[7:0];
            mem[{ram_addr[11:2], 2'd1}] = ram_din[15:8];
            mem[{ram_addr[11:2], 2'd2}] = ram_din[23:16];
            mem[{ram_addr[11:2], 2'd3}] = ram_din[31:24];
          end
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we, input logic [2:0] mode,
                       input logic [11:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      m0_req = req; m0_we = we; m0_mode = mode; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_mode = mode; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // One isolated transaction, entered at a negedge with the arbiter idle.
  task automatic txn(input string tag, input int port, input logic we, input logic [2:0] mode,
                     input logic [11:0] addr, input logic [31:0] wdata, input logic exp_we,
                     input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
    drive(port, 1'b1, we, mode, addr, wdata);
    #1;
    chk1({tag, "_gnt"}, (port == 0) ? m0_gnt : m1_gnt, 1'b1);
    chk1({tag, "_gnt_other"}, (port == 0) ? m1_gnt : m0_gnt, 1'b0);
    @(negedge clk);
    drive(port, 1'b0, 1'b0, MODE_W, 12'h000, 32'h0);
    chk1({tag, "_ram_we"}, ram_we, exp_we);
    chk1({tag, "_rvalid_early"}, (port == 0) ? m0_rvalid : m1_rvalid, 1'b0);
    @(negedge clk);
    chk1({tag, "_rvalid"}, (port == 0) ? m0_rvalid : m1_rvalid, 1'b1);
    chk1({tag, "_rvalid_other"}, (port == 0) ? m1_rvalid : m0_rvalid, 1'b0);
    chk1({tag, "_rerr"}, (port == 0) ? m0_rerr : m1_rerr, exp_err);
    if (chk_rd) chk32({tag, "_rdata"}, (port == 0) ? m0_rdata : m1_rdata, exp_rd);
    @(negedge clk);
  endtask

  int exp_w;

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, MODE_W, 12'h000, 32'h0);
    drive(1, 1'b0, 1'b0, MODE_W, 12'h000, 32'h0);
    m0_req = 1'b1;
    @(negedge clk); #1;
    chk1("rst_m0_gnt", m0_gnt, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk32("rst_ram_mode", 32'(ram_mode), 32'h2);
    chk32("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk1("rst_m1_rerr", m1_rerr, 1'b0);
    chk32("rst_m0_rdata", m0_rdata, 32'h0);
    m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Word write then read-back on port 0.
    txn("w_w10", 0, 1'b1, MODE_W, 12'h010, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    txn("r_w10", 0, 1'b0, MODE_W, 12'h010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Byte store on port 1 and extension checks.
    txn("w_b13", 1, 1'b1, MODE_B, 12'h013, 32'h000000A5, 1'b1, 1'b0, 32'h0, 1'b0);
    txn("r_b13", 1, 1'b0, MODE_B, 12'h013, 32'h0, 1'b0, 1'b1, 32'hFFFFFFA5, 1'b0);
    txn("r_bu13", 1, 1'b0, MODE_BU, 12'h013, 32'h0, 1'b0, 1'b1, 32'h000000A5, 1'b0);
    txn("r_w10b", 1, 1'b0, MODE_W, 12'h010, 32'h0, 1'b0, 1'b1, 32'hA5ADBEEF, 1'b0);
    txn("r_h12", 0, 1'b0, MODE_H, 12'h012, 32'h0, 1'b0, 1'b1, 32'hFFFFA5AD, 1'b0);
    txn("r_hu12", 1, 1'b0, MODE_HU, 12'h012, 32'h0, 1'b0, 1'b1, 32'h0000A5AD, 1'b0);

    // Misaligned accesses.
    txn("mis_h11", 1, 1'b0, MODE_H, 12'h011, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    txn("mis_w22", 0, 1'b1, MODE_W, 12'h022, 32'h12345678, 1'b0, 1'b1, 32'h0, 1'b1);
    chk1("mis_m1_rerr_hold", m1_rerr, 1'b1);
    txn("r_w20", 0, 1'b0, MODE_W, 12'h020, 32'h0, 1'b0, 1'b1, 32'h0BADC0DE, 1'b0);

    // Reset pulsed during a port 1 write.
    drive(1, 1'b1, 1'b1, MODE_W, 12'h040, 32'hCAFEF00D);
    #1;
    chk1("rp_m1_gnt", m1_gnt, 1'b1);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, MODE_W, 12'h040, 32'h0);
    drive(1, 1'b1, 1'b0, MODE_W, 12'h004, 32'h0);
    chk1("rp_ram_we_before", ram_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("rp_ram_we_after", ram_we, 1'b0);
    chk1("rp_m0_gnt_in_rst", m0_gnt, 1'b0);
    chk1("rp_m1_gnt_in_rst", m1_gnt, 1'b0);
    @(negedge clk);
    chk1("rp_m1_rvalid", m1_rvalid, 1'b0);
    chk32("rp_m1_rdata", m1_rdata, 32'h0);
    rst = 1'b0;
    #1;

    // Both ports requesting reads continuously, starting right after reset.
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_RR_EN
      exp_w = k % 2;
`else
      exp_w = 0;
`endif
      chk1($sformatf("ct%0d_m0_gnt", k), m0_gnt, exp_w == 0);
      chk1($sformatf("ct%0d_m1_gnt", k), m1_gnt, exp_w == 1);
      @(negedge clk);
      chk1($sformatf("ct%0d_acc_gnt", k), m0_gnt || m1_gnt, 1'b0);
      if (k == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      @(negedge clk); #1;
      chk1($sformatf("ct%0d_rvalid", k), (exp_w == 0) ? m0_rvalid : m1_rvalid, 1'b1);
      chk32($sformatf("ct%0d_rdata", k), (exp_w == 0) ? m0_rdata : m1_rdata,
            (exp_w == 0) ? 32'h01020304 : 32'h55667788);
    end
    @(negedge clk);
    chk1("ct_idle_rvalid", m0_rvalid || m1_rvalid, 1'b0);

    // Back-to-back reads on port 0: second request accepted in RESP.
    drive(0, 1'b1, 1'b0, MODE_W, 12'h000, 32'h0);
    #1;
    chk1("bb_gnt0", m0_gnt, 1'b1);
    @(negedge clk);
    m0_addr = 12'h004;
    chk1("bb_acc_gnt", m0_gnt, 1'b0);
    @(negedge clk); #1;
    chk1("bb_rvalid0", m0_rvalid, 1'b1);
    chk32("bb_rdata0", m0_rdata, 32'h11223344);
    chk1("bb_gnt1", m0_gnt, 1'b1);
    @(negedge clk);
    m0_req = 1'b0;
    chk1("bb_gap_rvalid", m0_rvalid, 1'b0);
    @(negedge clk);
    chk1("bb_rvalid1", m0_rvalid, 1'b1);
    chk32("bb_rdata1", m0_rdata, 32'h55667788);
    @(negedge clk);
    chk1("bb_done_rvalid", m0_rvalid, 1'b0);
    chk32("bb_rdata_hold", m0_rdata, 32'h55667788);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the data RAM (combinational read, synchronous write, byte/half/word modes).
- Port 0 is the CPU load/store unit; port 1 is the debug/program-loader master.
- Accepts one request at a time, checks alignment, drives the RAM for exactly one cycle, and returns a registered response to the granted requester.

Parameters:
ADDR_W, 12, byte-address width (RAM word-index bits + 2)
DATA_W, 32, data width; only 32 supported

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
m0_req  in  1  port 0 request; held stable until m0_gnt
m0_we  in  1  port 0 write enable
m0_mode  in  3  port 0 access mode (RAM mode encoding)
m0_addr  in  ADDR_W  port 0 byte address
m0_wdata  in  DATA_W  port 0 store data (low bytes used for B/H)
m0_gnt  out  1  request accepted this cycle (combinational)
m0_rvalid  out  1  one-cycle response strobe
m0_rdata  out  DATA_W  load data (already extended by the RAM)
m0_rerr  out  1  misaligned-access error, valid with m0_rvalid
m1_req, m1_we, m1_mode, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_rerr  same as port 0
ram_we  out  1  RAM write enable
ram_mode  out  3  RAM mode
ram_addr  out  ADDR_W  RAM byte address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data (combinational)

Behaviour:
- FSM states:
  - IDLE: no access in flight.
  - ACCESS: RAM driven from latched request.
  - RESP: rvalid to owner.
- Reset (async): state = IDLE; all rvalid/rerr = 0; rdata = 0; owner = 0; last_gnt = 1.
- While rst is high, both gnt outputs are 0 and ram_we is 0.
- Grant:
  - Possible only in IDLE or RESP, when at least one req is high.
  - Exactly one gnt is asserted in that cycle.
  - The winner's we/mode/addr/wdata and port id are latched at that edge; next state = ACCESS.
- RESP with no req: next state = IDLE.
- ACCESS (one cycle):
  - ram_addr, ram_mode and ram_din come from the latched fields.
  - ram_we = latched we AND NOT misaligned. The write commits at the edge ending ACCESS.
  - At that same edge, ram_dout is captured into the owner's rdata. If misaligned, rdata = 0 and rerr = 1.
  - Next state = RESP.
- RESP: owner's rvalid = 1 for exactly one cycle. rdata/rerr hold until the next response to that port. The non-owner's rvalid = 0.
- Outside ACCESS: ram_we = 0, ram_mode = 3'b010, ram_addr = 0, ram_din = 0.
- Latency:
  - Accept at cycle T; write visible from T+2; rvalid at T+2.
  - Back-to-back throughput: one access per 2 cycles.
- Misalignment:
  - mode[1:0] = 01 with addr[0] = 1.
  - mode[1:0] in {10, 11} with addr[1:0] != 0.
  - Byte accesses are never misaligned.
  - For writes, rvalid still fires (write acknowledge) with rdata = captured read of the target word, or 0 if misaligned.
- Arbitration (default): fixed priority, port 0 wins ties.
- Address is not range-checked; upper bits wrap per RAM indexing.
- Async reset during ACCESS: the write is abandoned (ram_we drops immediately) and no rvalid is issued.
- Requests deasserted without a gnt are simply dropped.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration on ties: the port not equal to last_gnt wins.
  - last_gnt updates on every grant and resets to 1, so port 0 wins the first tie.
- Undefined:
  - Fixed priority, port 0 always wins ties.
  - last_gnt is not implemented.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - Mode constants: MODE_B = 3'b000, MODE_H = 3'b001, MODE_W = 3'b010, MODE_BU = 3'b100, MODE_HU = 3'b101.
  - Function is_misaligned(mode, addr[1:0]).
- Sub-module ram_arb_pick: combinational 2-way picker.
  - Inputs: req0, req1, last_gnt.
  - Output: one-hot gnt.
  - Contains the RAM_ARB_RR_EN logic.

Test Plan:
- m0 write MODE_W 0xDEADBEEF @0x010, then m0 read MODE_W @0x010 -> m0_gnt at T, m0_rvalid at T+2, m0_rdata = 0xDEADBEEF, rerr = 0.
- m1 write MODE_B 0xA5 @0x013, then reads MODE_B and MODE_BU @0x013 -> 0xFFFFFFA5, then 0x000000A5; bytes 0x010..0x012 unchanged.
- m0 and m1 both requesting reads continuously:
  - Fixed priority: grants m0, m0, m0 (m1 starves).
  - With RAM_ARB_RR_EN: grants m0, m1, m0, m1 at T, T+2, T+4, T+6.
- m0 write MODE_W 0x12345678 @0x022 -> ram_we stays 0, m0_rvalid at T+2 with rerr = 1, rdata = 0; word @0x020 unchanged on read-back.
- m1 write MODE_W 0xCAFEF00D @0x040, rst pulsed during ACCESS -> ram_we falls immediately, no m1_rvalid, word @0x040 unchanged; arbiter grants again the first cycle after rst deasserts.
- m0 holds req for two reads @0x000 and @0x004 -> gnt at T and T+2 (second accepted in RESP), rvalid at T+2 and T+4, no idle cycle between.
